// File: rtl/eeg_sample_loader.sv
// ADC-to-memory window loader: accepts 16-bit ADC samples through a small FIFO and
// writes them zero-extended to consecutive int-res memory addresses, pulsing done per window.
`timescale 1ns/1ps
module eeg_sample_loader #(
  parameter int BASE_ADDR   = 0,
  parameter int NUM_SAMPLES = 3840,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 30,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              adc_valid,
  input  logic [15:0]       adc_data,
  output logic              adc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic [11:0]       sample_cnt
);

  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [11:0]       NUM_C   = 12'(NUM_SAMPLES);
  localparam logic [11:0]       LAST_C  = 12'(NUM_SAMPLES - 1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [11:0]      acc_cnt_q, acc_cnt_d;
  logic [11:0]      smp_cnt_q, smp_cnt_d;
  logic             req_q, req_d;
  logic             push, pop, fifo_full;

  // The write counter must never run past the window, so the address cannot wrap.
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v >= NUM_C) ? NUM_C : v + 12'd1;
  endfunction

  assign fifo_full  = (count_q == DEPTH_C);
  assign adc_ready  = (state_q == S_LOAD) && !fifo_full && (acc_cnt_q < NUM_C);
  assign push       = adc_valid && adc_ready;
  assign pop        = req_q && mem_gnt;

  assign mem_req    = req_q;
  assign mem_addr   = req_q ? (BASE_C + ADDR_W'(smp_cnt_q)) : '0;
  assign mem_wdata  = req_q ? {{(DATA_W-16){1'b0}}, fifo_q[rd_ptr_q]} : '0;
  assign busy       = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = smp_cnt_q;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    smp_cnt_d = smp_cnt_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      acc_cnt_d = sat_inc(acc_cnt_q);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      smp_cnt_d = sat_inc(smp_cnt_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_LOAD;
          acc_cnt_d = '0;
          smp_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (abort)                   state_d = S_IDLE;
        else if (acc_cnt_d == NUM_C) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                             state_d = S_IDLE;
        else if (pop && (smp_cnt_q == LAST_C)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort discards whatever is still buffered; a grant in the same cycle still counts.
    if (abort) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    req_d = (count_d != '0) && ((state_d == S_LOAD) || (state_d == S_DRAIN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      acc_cnt_q <= '0;
      smp_cnt_q <= '0;
      req_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      acc_cnt_q <= acc_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      req_q     <= req_d;
      if (push) fifo_q[wr_ptr_q] <= adc_data;
    end
  end

endmodule
